mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4: max consecutive data-port grants while fetch waits.
REQ-002 Parameter TIMEOUT, default 255: max wait cycles for m_ack before abort.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 if_req  in  1  fetch request; level, held with if_addr stable until if_valid.
REQ-006 if_addr  in  32  fetch address.
REQ-007 if_rdata  out  32  fetched instruction; holds until next if_valid.
REQ-008 if_valid  out  1  one-cycle pulse: fetch complete.
REQ-009 d_req  in  1  data request; level, held with d_we/d_addr/d_wdata stable until d_valid.
REQ-010 d_we  in  1  1 = store, 0 = load.
REQ-011 d_addr  in  32  data address.
REQ-012 d_wdata  in  32  store data.
REQ-013 d_rdata  out  32  load data; holds until next load d_valid.
REQ-014 d_valid  out  1  one-cycle pulse: data access complete.
REQ-015 m_req  out  1  memory request, high throughout a transaction.
REQ-016 m_we  out  1  memory write enable.
REQ-017 m_addr  out  32  memory address.
REQ-018 m_wdata  out  32  memory write data.
REQ-019 m_ack  in  1  memory completion, one cycle; m_rdata valid same cycle.
REQ-020 m_rdata  in  32  memory read data.
REQ-021 stall_if  out  1  combinational if_req & ~if_valid.
REQ-022 stall_mem  out  1  combinational d_req & ~d_valid.
REQ-023 err  out  1  one-cycle pulse with the valid of a timed-out transaction.

Function
REQ-024 FSM states IDLE, BUSY_I, BUSY_D; m_req = (state != IDLE).
REQ-025 IDLE arbitration: d_req & (~if_req | starve_cnt < STARVE_MAX) -> BUSY_D; else if_req -> BUSY_I; else stay IDLE.
REQ-026 On entering BUSY_*, requester address/we/wdata are latched; m_addr/m_we/m_wdata driven only from latches; m_we = 0 in BUSY_I and IDLE.
REQ-027 starve_cnt (3 bits): on BUSY_D grant with if_req high, increment saturating at STARVE_MAX; on BUSY_I grant, clear; otherwise hold.
REQ-028 BUSY_x with m_ack: next state IDLE; x_valid registered high next cycle; load/fetch rdata register captures m_rdata; store leaves d_rdata unchanged.
REQ-029 Latency: request sampled at edge N, m_req high in cycle N+1, zero-wait ack in cycle N+1 gives valid in cycle N+2.
REQ-030 The valid cycle is an IDLE cycle; a req still high then is arbitrated as a new request (back-to-back allowed).
REQ-031 wait_cnt (8 bits) clears on grant, increments each BUSY cycle without m_ack; at wait_cnt == TIMEOUT: to IDLE, valid and err pulse, rdata register loaded with 0.
REQ-032 m_ack and timeout in same cycle: ack wins, err stays 0.
REQ-033 m_ack while IDLE is ignored; no valid, no state change.
REQ-034 Requests dropped mid-transaction do not abort it; completion still pulses valid.
REQ-035 At most one of if_valid/d_valid is high in any cycle.

Reset
REQ-036 reset: state IDLE, starve_cnt 0, wait_cnt 0, all latches and rdata registers 0, m_req/m_we/if_valid/d_valid/err 0 in the following cycle.
REQ-037 reset mid-transaction aborts with no valid pulse; a late m_ack after reset is ignored.

Verification
REQ-038 if_req=1, if_addr=0x100, m_ack same cycle as m_req, m_rdata=0x00500093 -> m_addr=0x100, if_valid pulse 2 cycles after request, if_rdata=0x00500093.
REQ-039 if_req and d_req (load, 0x2000) held together, ack 0 waits -> grants D,D,D,D,I (STARVE_MAX=4), starve_cnt back to 0 after I grant.
REQ-040 d_req store d_addr=0x40, d_wdata=0xDEADBEEF, ack after 3 wait cycles -> m_we=1, m_wdata=0xDEADBEEF for 4 cycles, d_valid one pulse, d_rdata unchanged.
REQ-041 TIMEOUT=4, d_req load, no ack -> d_valid and err pulse after 4 wait cycles, d_rdata=0, state IDLE.
REQ-042 reset asserted while BUSY_I, m_ack arrives next cycle -> no if_valid, m_req 0, state IDLE.
REQ-043 m_ack coincident with wait_cnt==TIMEOUT, m_rdata=0x1234 -> valid pulse, err=0, rdata=0x1234.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single memory bus, with data-port
// priority bounded by a starvation counter and a per-transaction ack timeout.
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_ack,
  input  logic [31:0] m_rdata,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  localparam logic [2:0] STARVE_LIM  = 3'(STARVE_MAX);
  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT);

  state_t      r_state, w_next_state;
  logic [2:0]  r_starve_cnt;
  logic [7:0]  r_wait_cnt;
  logic [31:0] r_addr, r_wdata;
  logic        r_we;
  logic [31:0] r_if_rdata, r_d_rdata;
  logic        r_if_valid, r_d_valid, r_err;
  logic        w_grant_d, w_grant_i, w_ack, w_timeout;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Ack is tested before timeout so a coincident ack completes normally.
  always_comb begin
    w_next_state = r_state;
    w_grant_d    = 1'b0;
    w_grant_i    = 1'b0;
    w_ack        = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      IDLE: begin
        if (d_req && (!if_req || (r_starve_cnt < STARVE_LIM))) begin
          w_grant_d    = 1'b1;
          w_next_state = BUSY_D;
        end else if (if_req) begin
          w_grant_i    = 1'b1;
          w_next_state = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (m_ack) begin
          w_ack        = 1'b1;
          w_next_state = IDLE;
        end else if (r_wait_cnt == TIMEOUT_LIM) begin
          w_timeout    = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve_cnt <= '0;
      r_wait_cnt   <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_we         <= 1'b0;
      r_if_rdata   <= '0;
      r_d_rdata    <= '0;
      r_if_valid   <= 1'b0;
      r_d_valid    <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_if_valid <= (r_state == BUSY_I) && (w_ack || w_timeout);
      r_d_valid  <= (r_state == BUSY_D) && (w_ack || w_timeout);
      r_err      <= w_timeout;

      if (w_grant_d) begin
        r_addr     <= d_addr;
        r_we       <= d_we;
        r_wdata    <= d_wdata;
        r_wait_cnt <= '0;
        if (if_req && (r_starve_cnt != STARVE_LIM))
          r_starve_cnt <= r_starve_cnt + 3'd1;
      end else if (w_grant_i) begin
        r_addr       <= if_addr;
        r_we         <= 1'b0;
        r_wdata      <= '0;
        r_wait_cnt   <= '0;
        r_starve_cnt <= '0;
      end else if ((r_state != IDLE) && !w_ack && !w_timeout) begin
        r_wait_cnt <= r_wait_cnt + 8'd1;
      end

      if (r_state == BUSY_I) begin
        if (w_ack)          r_if_rdata <= m_rdata;
        else if (w_timeout) r_if_rdata <= '0;
      end

      // Stores never disturb the load-data register.
      if ((r_state == BUSY_D) && !r_we) begin
        if (w_ack)          r_d_rdata <= m_rdata;
        else if (w_timeout) r_d_rdata <= '0;
      end
    end
  end

  assign m_req     = (r_state != IDLE);
  assign m_we      = (r_state == BUSY_D) && r_we;
  assign m_addr    = r_addr;
  assign m_wdata   = r_wdata;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign if_valid  = r_if_valid;
  assign d_valid   = r_d_valid;
  assign err       = r_err;
  assign stall_if  = if_req & ~r_if_valid;
  assign stall_mem = d_req & ~r_d_valid;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; the bench plays the memory and checks each
// cycle against hand-computed expectations.
module tb_mem_arbiter;

  logic        clk, reset;
  logic        if_req, d_req, d_we, m_ack;
  logic [31:0] if_addr, d_addr, d_wdata, m_rdata;
  logic [31:0] if_rdata, d_rdata, m_addr, m_wdata;
  logic        if_valid, d_valid, m_req, m_we, stall_if, stall_mem, err;

  int unsigned errors = 0;
  int unsigned checks = 0;

  mem_arbiter #(.STARVE_MAX(4), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; m_ack = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; m_rdata = '0;
    tick(); tick();
    checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL reset_mreq: got %b want 0", m_req); end
    checks++; if (m_we !== 1'b0) begin errors++; $display("FAIL reset_mwe: got %b want 0", m_we); end
    checks++; if ({if_valid, d_valid, err} !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b want 000", {if_valid, d_valid, err}); end
    checks++; if (m_addr !== 32'h0) begin errors++; $display("FAIL reset_maddr: got %h want 0", m_addr); end
    checks++; if ({if_rdata, d_rdata} !== 64'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", {if_rdata, d_rdata}); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_idle_ack();
    m_ack = 1'b1; m_rdata = 32'hFFFF_FFFF;
    tick(); tick();
    checks++; if ({if_valid, d_valid} !== 2'b00) begin errors++; $display("FAIL idle_ack_valid: got %b want 00", {if_valid, d_valid}); end
    checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL idle_ack_mreq: got %b want 0", m_req); end
    checks++; if (if_rdata !== 32'h0) begin errors++; $display("FAIL idle_ack_rdata: got %h want 0", if_rdata); end
    m_ack = 1'b0; m_rdata = '0;
  endtask

  task automatic test_fetch();
    if_req = 1'b1; if_addr = 32'h100;
    tick();
    checks++; if (m_req !== 1'b1) begin errors++; $display("FAIL fetch_mreq: got %b want 1", m_req); end
    checks++; if (m_addr !== 32'h100) begin errors++; $display("FAIL fetch_maddr: got %h want 100", m_addr); end
    checks++; if (m_we !== 1'b0) begin errors++; $display("FAIL fetch_mwe: got %b want 0", m_we); end
    checks++; if (stall_if !== 1'b1) begin errors++; $display("FAIL fetch_stall_busy: got %b want 1", stall_if); end
    m_ack = 1'b1; m_rdata = 32'h0050_0093;
    tick();
    checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL fetch_valid: got %b want 1", if_valid); end
    checks++; if (if_rdata !== 32'h0050_0093) begin errors++; $display("FAIL fetch_rdata: got %h want 00500093", if_rdata); end
    checks++; if ({m_req, d_valid, err} !== 3'b000) begin errors++; $display("FAIL fetch_done_flags: got %b want 000", {m_req, d_valid, err}); end
    checks++; if (stall_if !== 1'b0) begin errors++; $display("FAIL fetch_stall_valid: got %b want 0", stall_if); end
    if_req = 1'b0; m_ack = 1'b0; m_rdata = '0;
    tick();
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL fetch_pulse_width: got %b want 0", if_valid); end
    checks++; if (if_rdata !== 32'h0050_0093) begin errors++; $display("FAIL fetch_rdata_hold: got %h want 00500093", if_rdata); end
  endtask

  task automatic test_back_to_back();
    if_req = 1'b1; if_addr = 32'h200;
    tick();
    m_ack = 1'b1; m_rdata = 32'h1111_0000;
    tick();
    checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid0: got %b want 1", if_valid); end
    if_addr = 32'h204; m_ack = 1'b0; m_rdata = '0;
    tick();
    checks++; if (m_req !== 1'b1 || m_addr !== 32'h204) begin errors++; $display("FAIL b2b_second_grant: got req=%b addr=%h want req=1 addr=204", m_req, m_addr); end
    m_ack = 1'b1; m_rdata = 32'h2222_0000;
    tick();
    checks++; if (if_valid !== 1'b1 || if_rdata !== 32'h2222_0000) begin errors++; $display("FAIL b2b_valid1: got v=%b d=%h want v=1 d=22220000", if_valid, if_rdata); end
    if_req = 1'b0; m_ack = 1'b0; m_rdata = '0;
    tick();
  endtask

  task automatic test_starvation();
    bit          exp_d [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] exp_addr;
    logic [31:0] data;
    if_req = 1'b1; if_addr = 32'h300;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
    for (int k = 0; k < 6; k++) begin
      exp_addr = exp_d[k] ? 32'h2000 : 32'h300;
      data = 32'hA000_0000 + 32'(k);
      tick();
      checks++; if (m_req !== 1'b1 || m_addr !== exp_addr) begin errors++; $display("FAIL starve_grant%0d: got req=%b addr=%h want req=1 addr=%h", k, m_req, m_addr, exp_addr); end
      m_ack = 1'b1; m_rdata = data;
      tick();
      checks++; if ({d_valid, if_valid} !== {exp_d[k], ~exp_d[k]}) begin errors++; $display("FAIL starve_valid%0d: got d/i=%b%b want %b%b", k, d_valid, if_valid, exp_d[k], ~exp_d[k]); end
      checks++; if ((exp_d[k] ? d_rdata : if_rdata) !== data) begin errors++; $display("FAIL starve_rdata%0d: got %h want %h", k, exp_d[k] ? d_rdata : if_rdata, data); end
      m_ack = 1'b0; m_rdata = '0;
      if (k == 5) begin if_req = 1'b0; d_req = 1'b0; end
    end
    tick();
    checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL starve_idle: got %b want 0", m_req); end
  endtask

  task automatic test_store();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
    m_rdata = 32'h5555_5555;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (m_req !== 1'b1 || m_we !== 1'b1 || m_addr !== 32'h40 || m_wdata !== 32'hDEAD_BEEF) begin
        errors++; $display("FAIL store_bus%0d: got req=%b we=%b addr=%h wdata=%h want 1 1 40 deadbeef", i, m_req, m_we, m_addr, m_wdata); end
      checks++; if (d_valid !== 1'b0 || stall_mem !== 1'b1) begin errors++; $display("FAIL store_wait%0d: got valid=%b stall=%b want 0 1", i, d_valid, stall_mem); end
      if (i == 3) m_ack = 1'b1;
    end
    tick();
    checks++; if (d_valid !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL store_valid: got valid=%b err=%b want 1 0", d_valid, err); end
    checks++; if (d_rdata !== 32'hA000_0005) begin errors++; $display("FAIL store_rdata_kept: got %h want a0000005", d_rdata); end
    d_req = 1'b0; d_we = 1'b0; m_ack = 1'b0; m_rdata = '0;
    tick();
    checks++; if (d_valid !== 1'b0 || m_we !== 1'b0) begin errors++; $display("FAIL store_after: got valid=%b we=%b want 0 0", d_valid, m_we); end
  endtask

  task automatic test_timeout();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (m_req !== 1'b1 || d_valid !== 1'b0 || err !== 1'b0) begin
        errors++; $display("FAIL timeout_wait%0d: got req=%b valid=%b err=%b want 1 0 0", i, m_req, d_valid, err); end
    end
    tick();
    checks++; if (d_valid !== 1'b1 || err !== 1'b1) begin errors++; $display("FAIL timeout_pulse: got valid=%b err=%b want 1 1", d_valid, err); end
    checks++; if (d_rdata !== 32'h0 || m_req !== 1'b0) begin errors++; $display("FAIL timeout_state: got rdata=%h req=%b want 0 0", d_rdata, m_req); end
    d_req = 1'b0;
    tick();
    checks++; if (err !== 1'b0 || d_valid !== 1'b0) begin errors++; $display("FAIL timeout_pulse_width: got err=%b valid=%b want 0 0", err, d_valid); end
  endtask

  task automatic test_ack_at_timeout();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h84;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (m_req !== 1'b1) begin errors++; $display("FAIL ackto_busy: got %b want 1", m_req); end
    m_ack = 1'b1; m_rdata = 32'h1234;
    tick();
    checks++; if (d_valid !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL ackto_pulse: got valid=%b err=%b want 1 0", d_valid, err); end
    checks++; if (d_rdata !== 32'h1234) begin errors++; $display("FAIL ackto_rdata: got %h want 1234", d_rdata); end
    d_req = 1'b0; m_ack = 1'b0; m_rdata = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    if_req = 1'b1; if_addr = 32'h500;
    tick();
    checks++; if (m_req !== 1'b1) begin errors++; $display("FAIL rstmid_busy: got %b want 1", m_req); end
    reset = 1'b1;
    tick();
    checks++; if (m_req !== 1'b0 || if_valid !== 1'b0) begin errors++; $display("FAIL rstmid_abort: got req=%b valid=%b want 0 0", m_req, if_valid); end
    checks++; if (m_addr !== 32'h0 || d_rdata !== 32'h0) begin errors++; $display("FAIL rstmid_clear: got addr=%h drdata=%h want 0 0", m_addr, d_rdata); end
    reset = 1'b0; if_req = 1'b0; m_ack = 1'b1; m_rdata = 32'h0BAD;
    tick();
    checks++; if (if_valid !== 1'b0 || m_req !== 1'b0 || if_rdata !== 32'h0) begin
      errors++; $display("FAIL rstmid_late_ack: got valid=%b req=%b rdata=%h want 0 0 0", if_valid, m_req, if_rdata); end
    m_ack = 1'b0; m_rdata = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_idle_ack();
    test_fetch();
    test_back_to_back();
    test_starvation();
    test_store();
    test_timeout();
    test_ack_at_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
